// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// requester port IDs and timeout counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int   CNT_W  = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on a tie; otherwise data always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`endif
  output logic grant
);

  always_comb begin
    grant = PORT_F;
    if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      // On a tie, favour whichever port was not granted last time.
      grant = ~last;
`else
      grant = PORT_D;
`endif
    end else if (d_req) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mux2_32.sv
// Existing 2:1 32-bit mux placed in front of the memory port.
module mux2_32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between fetch and load/store requesters,
// with a timeout watchdog. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        mem_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        f_done,
  output logic        d_done,
  output logic        err
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_d, we_d, f_done_d, d_done_d, err_d, grant;
  logic [31:0]      rdata_d;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  mem_arb_pick u_pick (.f_req(f_req), .d_req(d_req), .last(last_q), .grant(grant));
`else
  mem_arb_pick u_pick (.f_req(f_req), .d_req(d_req), .grant(grant));
`endif

  mux2_32 u_addr_mux  (.sel(mem_sel), .a(f_addr), .b(d_addr),  .y(mem_addr));
  mux2_32 u_wdata_mux (.sel(mem_sel), .a(32'd0),  .b(d_wdata), .y(mem_wdata));

  assign mem_req = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = mem_sel;
    we_d     = mem_we;
    rdata_d  = rdata;
    f_done_d = 1'b0;
    d_done_d = 1'b0;
    err_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          state_d = (grant == PORT_D) ? BUSY_D : BUSY_F;
          sel_d   = grant;
          we_d    = (grant == PORT_D) ? d_we : 1'b0;
          cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
          last_d  = grant;
`endif
        end
      end
      BUSY_F, BUSY_D: begin
        // Completion and timeout both end the transaction; only a timeout flags err.
        if (mem_ready || cnt_q == TO_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          we_d     = 1'b0;
          f_done_d = (state_q == BUSY_F);
          d_done_d = (state_q == BUSY_D);
          err_d    = !mem_ready;
          if (mem_ready) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_sel <= 1'b0;
      mem_we  <= 1'b0;
      rdata   <= '0;
      f_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_sel <= sel_d;
      mem_we  <= we_d;
      rdata   <= rdata_d;
      f_done  <= f_done_d;
      d_done  <= d_done_d;
      err     <= err_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_F;
    else        last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [31:0] d_wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_sel, mem_req, mem_we, f_done, d_done, err;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .mem_sel(mem_sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rdata(rdata), .f_done(f_done), .d_done(d_done), .err(err)
  );

  // Transaction-level model: who owns the port, how long it has waited,
  // and which completion pulses the last clock edge should have produced.
  bit          m_busy, m_own, m_sel, m_we, m_fd, m_dd, m_err, m_last;
  int          m_waited;
  logic [31:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_own = 0; m_sel = 0; m_we = 0; m_fd = 0; m_dd = 0;
      m_err = 0; m_last = 0; m_waited = 0; m_rdata = '0;
    end else begin
      m_fd = 0; m_dd = 0; m_err = 0;
      if (!m_busy) begin
        if (f_req || d_req) begin
          if (f_req && d_req) m_own = RR ? !m_last : 1'b1;
          else                m_own = d_req;
          m_busy = 1; m_waited = 0; m_sel = m_own; m_last = m_own;
          m_we = m_own ? d_we : 1'b0;
        end
      end else begin
        m_waited++;
        if (mem_ready || m_waited == TO) begin
          if (mem_ready) m_rdata = mem_rdata;
          else           m_err = 1;
          if (m_own) m_dd = 1; else m_fd = 1;
          m_busy = 0; m_we = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("m.mem_req",   32'(mem_req),   32'(m_busy));
      checkOutput("m.mem_sel",   32'(mem_sel),   32'(m_sel));
      checkOutput("m.mem_we",    32'(mem_we),    32'(m_we));
      checkOutput("m.f_done",    32'(f_done),    32'(m_fd));
      checkOutput("m.d_done",    32'(d_done),    32'(m_dd));
      checkOutput("m.err",       32'(err),       32'(m_err));
      checkOutput("m.rdata",     rdata,          m_rdata);
      checkOutput("m.mem_addr",  mem_addr,       m_sel ? d_addr : f_addr);
      checkOutput("m.mem_wdata", mem_wdata,      m_sel ? d_wdata : 32'd0);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic dr,
                               input logic [31:0] da, input logic we, input logic [31:0] wd,
                               input logic rdy, input logic [31:0] rd);
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_we = we; d_wdata = wd;
    mem_ready = rdy; mem_rdata = rd;
  endtask

  int fw, dw;
  logic exp_rr [3];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    checkOutput("reset.mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset.rdata",   rdata,        32'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("reset.f_done",  32'(f_done),  32'd0);

    // Single fetch, ready in the first BUSY cycle
    applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    stepCycle();
    checkOutput("fetch.mem_req",  32'(mem_req), 32'd1);
    checkOutput("fetch.mem_sel",  32'(mem_sel), 32'd0);
    checkOutput("fetch.mem_addr", mem_addr,     32'h100);
    mem_ready = 1; mem_rdata = 32'h00500093;
    stepCycle();
    checkOutput("fetch.f_done",   32'(f_done),  32'd1);
    checkOutput("fetch.rdata",    rdata,        32'h00500093);
    applyStimulus(0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    stepCycle();
    checkOutput("fetch.f_done_off", 32'(f_done), 32'd0);

    // Simultaneous requests from a fresh reset, three rounds
    rst_n = 1'b0; #1; rst_n = 1'b1;
    exp_rr[0] = 1'b1;
    exp_rr[1] = RR ? 1'b0 : 1'b1;
    exp_rr[2] = 1'b1;
    applyStimulus(1, 32'h400, 1, 32'h800, 0, 32'h0, 1, 32'h11112222);
    for (int r = 0; r < 3; r++) begin
      stepCycle();
      checkOutput($sformatf("rounds.sel%0d", r), 32'(mem_sel), 32'(exp_rr[r]));
      stepCycle();
    end
    applyStimulus(0, 32'h400, 0, 32'h800, 0, 32'h0, 0, 32'h0);
    stepCycle();

    // Store with three BUSY cycles
    applyStimulus(0, 32'h0, 1, 32'h200, 1, 32'hDEADBEEF, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("store.mem_we%0d", c),  32'(mem_we),  32'd1);
      checkOutput($sformatf("store.mem_sel%0d", c), 32'(mem_sel), 32'd1);
      checkOutput($sformatf("store.d_done%0d", c),  32'(d_done),  32'd0);
    end
    checkOutput("store.wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1; mem_rdata = 32'h12345678;
    stepCycle();
    checkOutput("store.d_done", 32'(d_done), 32'd1);
    checkOutput("store.mem_req", 32'(mem_req), 32'd0);
    checkOutput("store.rdata", rdata, 32'h12345678);
    applyStimulus(0, 32'h0, 0, 32'h200, 0, 32'h0, 0, 32'h0);
    stepCycle();

    // Timeout: memory never answers
    applyStimulus(0, 32'h0, 1, 32'h240, 0, 32'h0, 0, 32'h0);
    for (int c = 0; c < TO; c++) begin
      stepCycle();
      checkOutput($sformatf("timeout.busy%0d", c), 32'(mem_req), 32'd1);
    end
    stepCycle();
    checkOutput("timeout.d_done", 32'(d_done), 32'd1);
    checkOutput("timeout.err",    32'(err),    32'd1);
    checkOutput("timeout.rdata",  rdata,       32'h12345678);
    applyStimulus(1, 32'h280, 0, 32'h240, 0, 32'h0, 1, 32'h0BADF00D);
    stepCycle();
    checkOutput("timeout.err_off", 32'(err), 32'd0);
    stepCycle();
    checkOutput("after_to.f_done", 32'(f_done), 32'd1);
    checkOutput("after_to.rdata",  rdata,       32'h0BADF00D);
    applyStimulus(0, 32'h280, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    stepCycle();

    // Reset during BUSY_D
    applyStimulus(0, 32'h0, 1, 32'h500, 1, 32'h55AA55AA, 0, 32'h0);
    stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst.mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst.rdata",   rdata,        32'd0);
    d_req = 0; d_we = 0;
    stepCycle();
    checkOutput("rst.d_done",  32'(d_done),  32'd0);
    rst_n = 1'b1;
    applyStimulus(1, 32'h300, 0, 32'h0, 0, 32'h0, 1, 32'hCAFEF00D);
    stepCycle();
    checkOutput("rst.fetch_sel", 32'(mem_sel), 32'd0);
    stepCycle();
    checkOutput("rst.f_done", 32'(f_done), 32'd1);
    checkOutput("rst.rdata",  rdata,       32'hCAFEF00D);

    // mem_ready while IDLE is ignored
    applyStimulus(0, 32'h300, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF0000);
    stepCycle();
    stepCycle();
    checkOutput("idle_rdy.mem_req", 32'(mem_req), 32'd0);
    checkOutput("idle_rdy.done",    32'({f_done, d_done}), 32'd0);
    checkOutput("idle_rdy.rdata",   rdata,        32'hCAFEF00D);

    // Randomized traffic checked by the model every cycle
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    fw = 0; dw = 0;
    for (int c = 0; c < 3000; c++) begin
      stepCycle();
      if (f_req && f_done) begin f_req = 0; fw = 0; end
      if (d_req && d_done) begin d_req = 0; dw = 0; end
      if (!f_req && $urandom_range(0, 9) < 4) begin
        f_req = 1; f_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 9) < 4) begin
        d_req = 1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      if (f_req) fw++;
      if (d_req) dw++;
      if (fw > 200 || dw > 200) begin
        total++; bad++;
        $display("[TB] FAIL rand.wait: fetch waited %0d data waited %0d, limit 200", fw, dw);
        fw = 0; dw = 0;
      end
      mem_ready = ($urandom_range(0, 99) < 35);
      mem_rdata = $urandom;
    end
    f_req = 0; d_req = 0; mem_ready = 1;
    repeat (TO + 3) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares the processor's single 32-bit memory port between the instruction-fetch requester (port 0) and the load/store requester (port 1). It drives the select of the 2:1 32-bit address/data mux in front of memory, issues one registered memory transaction at a time, waits for a variable-latency `mem_ready`, and returns read data with a one-cycle `done` pulse. A timeout watchdog aborts hung transactions.

## Interface
- `TIMEOUT`, 255: max cycles in BUSY waiting for `mem_ready` before abort; 1..255.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch request, level, held until `f_done`.
- `f_addr` in 32: fetch address.
- `d_req` in 1: data request, level, held until `d_done`.
- `d_addr` in 32: data address.
- `d_we` in 1: data write enable.
- `d_wdata` in 32: store data.
- `mem_sel` out 1: mux select; 0 = fetch path, 1 = data path.
- `mem_req` out 1: memory transaction valid.
- `mem_we` out 1: memory write enable.
- `mem_ready` in 1: memory completes current transaction this cycle.
- `mem_rdata` in 32: memory read data, valid with `mem_ready`.
- `rdata` out 32: registered read data of last completed transaction.
- `f_done` out 1: one-cycle completion pulse, fetch.
- `d_done` out 1: one-cycle completion pulse, data.
- `err` out 1: one-cycle pulse on timeout abort; accompanies the owner's `done`.

## Operation
- States: IDLE, BUSY_F, BUSY_D.
- IDLE: if neither req high, stay. Otherwise pick a winner (see Configuration); next state BUSY_F/BUSY_D; `mem_sel`, `mem_we` (= `d_we` for data, 0 for fetch) registered on the same edge.
- BUSY_x: `mem_req`=1, `mem_sel` constant. Address/wdata flow combinationally through the mux from the owning requester, which must hold them stable.
- BUSY_x with `mem_ready`=1: `rdata` <= `mem_rdata` (also on writes), `x_done` pulses next cycle, state -> IDLE, timeout counter cleared.
- Timeout: 8-bit counter increments each BUSY cycle without `mem_ready`; on reaching `TIMEOUT`, state -> IDLE, `x_done`=1 and `err`=1 next cycle, `rdata` unchanged.
- Requester contract: req low in its `done` cycle unless issuing a new request; a req high in that cycle (state IDLE) is arbitrated as new.
- Non-owner req changes during BUSY are ignored until IDLE.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_sel` 0, `mem_we` 0, `rdata` 0, `f_done`/`d_done`/`err` 0, RR pointer 0, counter 0.
- Reset asserted mid-transaction: immediate abort, all outputs to reset values, no `done` emitted.
- Latency: req sampled in IDLE at edge N -> `mem_req` high cycle N+1 -> `mem_ready` earliest N+1 -> `done` cycle N+2.
- Minimum issue interval per transaction: 2 cycles (BUSY, IDLE).
- `mem_ready` while IDLE: ignored.
- `done` and `err` never exceed one cycle; at most one `done` per cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; 1-bit last-grant pointer updated on each grant; on simultaneous req, grant the port not last granted.
- Undefined: fixed priority, data port always wins simultaneous requests; no pointer register.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE, BUSY_F, BUSY_D), port ID constants `PORT_F`=0, `PORT_D`=1, timeout counter width 8.
- One sub-module: `mem_arb_pick`, combinational winner select (two reqs + pointer -> grant ID), containing the `MEM_ARB_RR_EN` logic.
- Existing 2:1 32-bit mux instantiated at top level, select tied to `mem_sel`.

## Test plan
- Single fetch: `f_req`=1, `f_addr`=0x100, `mem_ready` in first BUSY cycle with rdata 0x00500093 -> `mem_sel`=0, `f_done` at N+2, `rdata`=0x00500093.
- Simultaneous reqs, three back-to-back rounds -> RR build: grants D,F,D... alternating from reset pointer; fixed build: data every round while `d_req` held.
- Store with 3-cycle wait: `d_we`=1, `d_wdata`=0xDEADBEEF -> `mem_we`=1, `mem_sel`=1 for exactly 3 BUSY cycles, `d_done` one cycle later.
- Timeout: `TIMEOUT`=4, `mem_ready` never -> `d_done` and `err` pulse together 5 cycles after grant, `rdata` unchanged, next request serviced normally.
- `rst_n` low during BUSY_D -> `mem_req` 0 immediately, no `done`, fetch request after release granted normally.
- `mem_ready` pulsed in IDLE -> no state change, no `done`, `rdata` unchanged.
